// File: rtl/decode_ctrl_if.sv
// decode_ctrl_if: fetch-side, dispatch-side and flush signals of decode_ctrl in one bundle.
interface decode_ctrl_if;
    logic        flush_i;
    logic        in_valid_i;
    logic [31:0] in_pc_i;
    logic [31:0] in_instr_i;
    logic        in_excp_i;
    logic        in_ready_o;
    logic [31:0] dec_instr_o;
    logic        out_valid_o;
    logic [31:0] out_pc_o;
    logic        out_excp_o;
    logic        out_ready_i;
    logic [31:0] dispatch_cnt_o;
    modport slave (
        input  flush_i, in_valid_i, in_pc_i, in_instr_i, in_excp_i, out_ready_i,
        output in_ready_o, dec_instr_o, out_valid_o, out_pc_o, out_excp_o, dispatch_cnt_o
    );
    modport master (
        output flush_i, in_valid_i, in_pc_i, in_instr_i, in_excp_i, out_ready_i,
        input  in_ready_o, dec_instr_o, out_valid_o, out_pc_o, out_excp_o, dispatch_cnt_o
    );
endinterface

// File: rtl/decode_ctrl.sv
// decode_ctrl: circular instruction queue between fetch and dispatch, with a dispatch counter.
// Define DECODE_CTRL_BYPASS_EN to forward input straight to the outputs while the queue is empty.
module decode_ctrl #(
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    decode_ctrl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   disp_q, disp_d;
    logic [31:0]   pc_mem [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          excp_mem [DEPTH];
    logic          empty, byp, push, pop, fire;
    always_comb begin
        empty = cnt_q == '0;
`ifdef DECODE_CTRL_BYPASS_EN
        byp = empty && bus.in_valid_i && !bus.flush_i;
`else
        byp = 1'b0;
`endif
        bus.in_ready_o  = cnt_q != CW'(DEPTH);
        bus.out_valid_o = (!empty || byp) && !bus.flush_i;
        // a bypassed word taken by dispatch the same cycle never enters the queue
        push = bus.in_valid_i && bus.in_ready_o && !bus.flush_i && !(byp && bus.out_ready_i);
        fire = bus.out_valid_o && bus.out_ready_i;
        pop  = fire && !byp;
        bus.out_pc_o    = !bus.out_valid_o ? '0 : byp ? bus.in_pc_i : pc_mem[head_q];
        bus.dec_instr_o = !bus.out_valid_o ? '0 : byp ? bus.in_instr_i : instr_mem[head_q];
        bus.out_excp_o  = bus.out_valid_o && (byp ? bus.in_excp_i : excp_mem[head_q]);
        bus.dispatch_cnt_o = disp_q;
        head_d = bus.flush_i ? '0 : head_q + PW'(pop);
        tail_d = bus.flush_i ? '0 : tail_q + PW'(push);
        cnt_d  = bus.flush_i ? '0 : cnt_q + CW'(push) - CW'(pop);
        disp_d = disp_q + 32'(fire);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            disp_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            disp_q <= disp_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]    <= bus.in_pc_i;
            instr_mem[tail_q] <= bus.in_instr_i;
            excp_mem[tail_q]  <= bus.in_excp_i;
        end
    end
endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: directed checks of decode_ctrl (DEPTH=4) covering reset, latency, full, wrap, flush.
module tb_decode_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    decode_ctrl_if bus();
    decode_ctrl #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ex, input logic rdy);
        bus.in_valid_i  = v;
        bus.in_pc_i     = pc;
        bus.in_instr_i  = ins;
        bus.in_excp_i   = ex;
        bus.out_ready_i = rdy;
    endtask
    initial begin
        bus.flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_ready", 32'(bus.in_ready_o), 32'd1);
        chk("rst_instr", bus.dec_instr_o, 32'h0);
        chk("rst_pc", bus.out_pc_o, 32'h0);
        chk("rst_excp", 32'(bus.out_excp_o), 32'd0);
        chk("rst_disp", bus.dispatch_cnt_o, 32'd0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", 32'(bus.out_valid_o), 32'd0);
            chk("idle_ready", 32'(bus.in_ready_o), 32'd1);
            chk("idle_disp", bus.dispatch_cnt_o, 32'd0);
        end
        drive(1'b1, 32'h1C000000, 32'h02800C21, 1'b0, 1'b0);
        #1;
`ifdef DECODE_CTRL_BYPASS_EN
        chk("lat_same_cycle", 32'(bus.out_valid_o), 32'd1);
`else
        chk("lat_same_cycle", 32'(bus.out_valid_o), 32'd0);
`endif
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 32'(bus.out_valid_o), 32'd1);
            chk("hold_pc", bus.out_pc_o, 32'h1C000000);
            chk("hold_instr", bus.dec_instr_o, 32'h02800C21);
            chk("hold_disp", bus.dispatch_cnt_o, 32'd0);
            tick();
        end
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        chk("pop1_valid", 32'(bus.out_valid_o), 32'd0);
        chk("pop1_instr", bus.dec_instr_o, 32'h0);
        chk("pop1_disp", bus.dispatch_cnt_o, 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), i == 2, 1'b0);
            #1;
            chk("fill_ready", 32'(bus.in_ready_o), 32'd1);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("full_ready", 32'(bus.in_ready_o), 32'd0);
        drive(1'b1, 32'h200, 32'hBAD, 1'b0, 1'b1);
        #1;
        chk("full_ready_pop", 32'(bus.in_ready_o), 32'd0);
        chk("full_head_pc", bus.out_pc_o, 32'h100);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 1; i < 4; i++) begin
            chk("drain_valid", 32'(bus.out_valid_o), 32'd1);
            chk("drain_pc", bus.out_pc_o, 32'h100 + 32'(4 * i));
            chk("drain_instr", bus.dec_instr_o, 32'hA0 + 32'(i));
            chk("drain_excp", 32'(bus.out_excp_o), 32'(i == 2));
            tick();
        end
        chk("drain_empty", 32'(bus.out_valid_o), 32'd0);
        chk("drain_disp", bus.dispatch_cnt_o, 32'd5);
        drive(1'b1, 32'h300, 32'hC0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h304 + 32'(4 * k), 32'hC1 + 32'(k), 1'b0, 1'b1);
            #1;
            chk("stream_pc", bus.out_pc_o, 32'h300 + 32'(4 * k));
            chk("stream_ready", 32'(bus.in_ready_o), 32'd1);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("stream_valid", 32'(bus.out_valid_o), 32'd1);
        chk("stream_head", bus.out_pc_o, 32'h328);
        chk("stream_disp", bus.dispatch_cnt_o, 32'd15);
        drive(1'b1, 32'h400, 32'hD0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h404, 32'hD1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h500, 32'hEEE, 1'b1, 1'b1);
        bus.flush_i = 1'b1;
        #1;
        chk("flush_valid", 32'(bus.out_valid_o), 32'd0);
        chk("flush_instr", bus.dec_instr_o, 32'h0);
        tick();
        bus.flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("post_flush_valid", 32'(bus.out_valid_o), 32'd0);
        chk("post_flush_ready", 32'(bus.in_ready_o), 32'd1);
        chk("post_flush_disp", bus.dispatch_cnt_o, 32'd15);
        drive(1'b1, 32'h600, 32'hF0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("post_flush_pc", bus.out_pc_o, 32'h600);
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        chk("post_flush_empty", 32'(bus.out_valid_o), 32'd0);
        chk("post_flush_disp2", bus.dispatch_cnt_o, 32'd16);
        drive(1'b1, 32'h700, 32'h70, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h704, 32'h71, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready_o), 32'd1);
        chk("mid_rst_pc", bus.out_pc_o, 32'h0);
        chk("mid_rst_disp", bus.dispatch_cnt_o, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("after_rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("after_rst_disp", bus.dispatch_cnt_o, 32'd0);
`ifdef DECODE_CTRL_BYPASS_EN
        drive(1'b1, 32'h800, 32'h1234, 1'b0, 1'b1);
        #1;
        chk("byp_valid", 32'(bus.out_valid_o), 32'd1);
        chk("byp_pc", bus.out_pc_o, 32'h800);
        chk("byp_instr", bus.dec_instr_o, 32'h1234);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("byp_empty", 32'(bus.out_valid_o), 32'd0);
        chk("byp_disp", bus.dispatch_cnt_o, 32'd1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
